// File: rtl/systolic_result_collector_pkg.sv
// Purpose: shared types and defaults for the systolic result collector.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package systolic_result_collector_pkg;

    // Collector FSM encodings
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Default geometry, shared with systolic_array
    localparam int DEF_M          = 5;
    localparam int DEF_K          = 4;
    localparam int DEF_DATA_WIDTH = 8;

    // Index width for an n-entry array; never zero so M=1 still builds
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_collector_skew_delay.sv
// Purpose: DEPTH-stage shift register used to deskew one lane; DEPTH=0 is a plain wire.
// Latency: DEPTH cycles.
// Backpressure: none; shifts every cycle.
// Ports: clk, rst (async active-low), din/dout (DATA_WIDTH bits).
module systolic_result_collector_skew_delay #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        // The last lane needs no delay; clk/rst are only tied off here
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign dout           = din;
    end else begin : g_shift
        logic [DATA_WIDTH-1:0] stage_q [DEPTH];
        logic [DATA_WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_result_collector.sv
// Purpose: deskew the systolic array Y stream, buffer M aligned rows, drain them downstream.
// Latency: out_valid rises the cycle after edge t0+M+K-2 (t0 = edge sampling start).
// Backpressure: drain stalls on out_ready=0 with out_row held; capture cannot be stalled.
// Ports: clk, rst (async active-low), start, y_in (skewed lanes), out_row/out_valid/
//        out_ready/out_last (drain handshake), busy (not idle), overrun (sticky dropped start).
module systolic_result_collector
    import systolic_result_collector_pkg::*;
#(
    parameter int M          = DEF_M,
    parameter int K          = DEF_K,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH*K-1:0] y_in,
    output logic [DATA_WIDTH*K-1:0] out_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam int RW = DATA_WIDTH * K;
    localparam int CW = $clog2(M + K);
    localparam int AW = idx_width(M);

    localparam logic [CW-1:0] LAST_CNT = CW'(M + K - 2);
    localparam logic [CW-1:0] FIRST_WR = CW'(K - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(M - 1);

    // Lane j is delayed K-1-j cycles so all lanes of a row line up
    logic [RW-1:0] aligned_row;

    for (genvar j = 0; j < K; j++) begin : g_lane
        systolic_result_collector_skew_delay #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (K - 1 - j)
        ) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (y_in[DATA_WIDTH*j +: DATA_WIDTH]),
            .dout (aligned_row[DATA_WIDTH*j +: DATA_WIDTH])
        );
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overrun_q, overrun_d;
    logic [RW-1:0] buf_q [M];

    logic          handshake, final_hs, start_acc;
    logic [CW-1:0] cur_cnt;
    logic          wr_en;
    logic [AW-1:0] wr_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
        wr_idx    = '0;

        handshake = (state_q == DRAIN) && out_ready;
        final_hs  = handshake && (rd_ptr_q == LAST_ROW);
        // A start landing on the final handshake is taken with no idle bubble
        start_acc = start && ((state_q == IDLE) || final_hs);
        // The accepting edge is capture count 0, so it may already write (K=1)
        cur_cnt   = start_acc ? '0 : cnt_q;

        if (start) begin
            overrun_d = !start_acc;
        end

        if (handshake) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
            if (final_hs) begin
                state_d = IDLE;
            end
        end

        // Overrides the DRAIN->IDLE exit when a new matrix starts on that edge
        if (start_acc || (state_q == CAPTURE)) begin
            if (cur_cnt >= FIRST_WR) begin
                wr_en  = 1'b1;
                wr_idx = AW'(cur_cnt - FIRST_WR);
            end
            if (cur_cnt == LAST_CNT) begin
                state_d  = DRAIN;
                rd_ptr_d = '0;
            end else begin
                state_d = CAPTURE;
                cnt_d   = cur_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        out_valid = (state_q == DRAIN);
        out_last  = out_valid && (rd_ptr_q == LAST_ROW);
        out_row   = out_valid ? buf_q[AW'(rd_ptr_q)] : '0;
        busy      = (state_q != IDLE);
        overrun   = overrun_q;
    end

    // Buffer contents are don't-care after reset, so no reset on the array
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_idx] <= aligned_row;
        end
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Purpose: directed self-checking bench for systolic_result_collector (M=5, K=4, 8-bit).
// Latency: n/a.
// Backpressure: drives out_ready patterns (always-ready and 1,0,0 toggling).
module tb_systolic_result_collector;

    localparam int M  = 5;
    localparam int K  = 4;
    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [DW*K-1:0] y_in;
    logic [DW*K-1:0] out_row;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic            overrun;

    int checks   = 0;
    int failures = 0;
    logic [DW*K-1:0] exp_q [$];

    systolic_result_collector #(
        .M          (M),
        .K          (K),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .y_in      (y_in),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element Y[r][j] = base + 16*r + j, packed lane j at [8j +: 8]
    function automatic logic [DW*K-1:0] row_of(input logic [7:0] base, input int r);
        logic [DW*K-1:0] v;
        for (int j = 0; j < K; j++) begin
            v[DW*j +: DW] = base + 8'(16 * r + j);
        end
        return v;
    endfunction

    // Drives one skewed matrix starting now (called just after an edge).
    // extra_c: step with an additional start pulse; abort_c: step at which to stop early.
    task automatic feed(input logic [7:0] base, input bit chk_idle,
                        input int extra_c, input int abort_c);
        for (int c = 0; c <= M + K - 2; c++) begin
            if (c == abort_c) begin
                start = 1'b0;
                y_in  = '0;
                return;
            end
            if (chk_idle && c > 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL early_valid step=%0d out_valid=%b expected 0", c, out_valid);
                end
            end
            start = (c == 0) || (c == extra_c);
            for (int j = 0; j < K; j++) begin
                int r;
                r = c - j;
                y_in[DW*j +: DW] = (r >= 0 && r < M) ? base + 8'(16 * r + j) : 8'hEE;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        y_in  = '0;
    endtask

    // Accepts n rows, comparing each handshake against exp_q; toggle selects ready 1,0,0,...
    task automatic collect(input int n, input bit toggle);
        int              got     = 0;
        int              cyc     = 0;
        bit              stalled = 1'b0;
        logic [DW*K-1:0] held    = '0;
        logic [DW*K-1:0] e;
        logic            exp_last;
        while (got < n) begin
            if (cyc >= 200) begin
                checks++;
                failures++;
                $display("FAIL collect_timeout rows=%0d expected %0d", got, n);
                break;
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== held) begin
                    failures++;
                    $display("FAIL stall_hold valid=%b row=%h expected valid=1 row=%h",
                             out_valid, out_row, held);
                end
            end
            out_ready = !toggle || (cyc % 3 == 0);
            stalled   = 1'b0;
            if (out_valid === 1'b1 && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                exp_last = ((got % M) == M - 1);
                checks++;
                if (out_row !== e) begin
                    failures++;
                    $display("FAIL row_data idx=%0d got=%h expected %h", got, out_row, e);
                end
                checks++;
                if (out_last !== exp_last) begin
                    failures++;
                    $display("FAIL out_last idx=%0d got=%b expected %b", got, out_last, exp_last);
                end
                got++;
            end else if (out_valid === 1'b1) begin
                stalled = 1'b1;
                held    = out_row;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, out_last, busy, overrun, out_row} !== '0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b last=%b busy=%b ovr=%b row=%h expected all 0",
                     out_valid, out_last, busy, overrun, out_row);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_idle valid=%b busy=%b ovr=%b expected 0 0 0",
                     out_valid, busy, overrun);
        end
    endtask

    task automatic test_nominal();
        exp_q.push_back(32'h03020100);
        exp_q.push_back(32'h13121110);
        exp_q.push_back(32'h23222120);
        exp_q.push_back(32'h33323130);
        exp_q.push_back(32'h43424140);
        feed(8'h00, 1'b1, -1, -1);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_valid valid=%b busy=%b expected 1 1", out_valid, busy);
        end
        collect(5, 1'b0);
        checks++;
        if ({out_valid, out_last, busy} !== 3'b000) begin
            failures++;
            $display("FAIL nominal_done valid=%b last=%b busy=%b expected 0 0 0",
                     out_valid, out_last, busy);
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < M; r++) exp_q.push_back(row_of(8'h05, r));
        feed(8'h05, 1'b1, -1, -1);
        collect(5, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_done valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_overrun();
        for (int r = 0; r < M; r++) exp_q.push_back(row_of(8'h00, r));
        feed(8'h00, 1'b1, 3, -1);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_capture got=%b expected 1", overrun);
        end
        out_ready = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || out_row !== 32'h03020100) begin
            failures++;
            $display("FAIL overrun_drain ovr=%b valid=%b row=%h expected 1 1 03020100",
                     overrun, out_valid, out_row);
        end
        collect(5, 1'b0);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL overrun_sticky ovr=%b busy=%b expected 1 0", overrun, busy);
        end
    endtask

    task automatic test_simultaneous();
        for (int r = 0; r < M; r++) exp_q.push_back(row_of(8'h00, r));
        for (int r = 0; r < M; r++) exp_q.push_back(row_of(8'h80, r));
        feed(8'h00, 1'b1, -1, -1);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_cleared got=%b expected 0", overrun);
        end
        fork
            begin
                // Start lands on the edge of the 5th (final) handshake
                repeat (4) begin @(posedge clk); #1; end
                feed(8'h80, 1'b0, -1, -1);
            end
            collect(10, 1'b0);
            begin
                repeat (5) begin @(posedge clk); #1; end
                checks++;
                if (busy !== 1'b1 || overrun !== 1'b0 || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL simultaneous_start busy=%b ovr=%b valid=%b expected 1 0 0",
                             busy, overrun, out_valid);
                end
            end
        join
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL simultaneous_done busy=%b ovr=%b expected 0 0", busy, overrun);
        end
    endtask

    task automatic test_reset_mid_capture();
        for (int r = 0; r < M; r++) exp_q.push_back(row_of(8'h90, r));
        feed(8'h30, 1'b1, -1, 4);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet cyc=%0d valid=%b busy=%b expected 0 0",
                         i, out_valid, busy);
            end
        end
        feed(8'h90, 1'b1, -1, -1);
        collect(5, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_done valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_values();
        for (int r = 0; r < M - 1; r++) exp_q.push_back(row_of(8'h50, r));
        feed(8'h50, 1'b1, 2, -1);
        collect(4, 1'b0);
        checks++;
        if ({out_valid, out_last, busy, overrun} !== 4'b1111 || out_row !== 32'h93929190) begin
            failures++;
            $display("FAIL pre_reset valid=%b last=%b busy=%b ovr=%b row=%h expected 1 1 1 1 93929190",
                     out_valid, out_last, busy, overrun, out_row);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, busy, overrun} !== 4'b0000 || out_row !== '0) begin
            failures++;
            $display("FAIL async_reset valid=%b last=%b busy=%b ovr=%b row=%h expected all 0",
                     out_valid, out_last, busy, overrun, out_row);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release valid=%b busy=%b ovr=%b expected 0 0 0",
                     out_valid, busy, overrun);
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        y_in      = '0;
        out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_overrun();
        test_simultaneous();
        test_reset_mid_capture();
        test_reset_values();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
